collider_seq: RTL and testbench

//  Frame-level track extraction scheduler for the ALCT wiregroup collider stage.
//  - Accepts one BX frame of four quality planes (qp0..qp3, qp3 = best quality)

---
 rtl/collider_pkg.sv | 13 +
 rtl/collider_pick.sv | 49 ++++
 rtl/collider_seq.sv | 130 +++++++++++++
 tb/tb_collider_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collider_pkg.sv
// Shared widths, codes and FSM encoding for the wiregroup collider track scheduler.
package collider_pkg;
  localparam int NWG_DEF = 48;
  localparam int WG_W    = 7;
  localparam int Q_W     = 2;
  localparam logic [WG_W-1:0] NO_WG = 7'h7f;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;
endpackage

// File: rtl/collider_pick.sv
// Combinational best-track picker: highest quality plane first, lowest wiregroup within it,
// plus the ghost-cleared copy of all four planes around the picked wiregroup.
module collider_pick
  import collider_pkg::*;
#(
  parameter int NWG     = NWG_DEF,
  parameter int GHOST_W = 1
) (
  input  logic [3:0][NWG-1:0] p,
  output logic                found,
  output logic [WG_W-1:0]     wg,
  output logic [Q_W-1:0]      q,
  output logic [3:0][NWG-1:0] p_clr,
  output logic                any_left
);
  int pick_idx;
  int pick_q;

  always_comb begin
    found    = 1'b0;
    pick_idx = 0;
    pick_q   = 0;
    for (int qi = 3; qi >= 0; qi--) begin
      if (!found && (p[qi] != '0)) begin
        found  = 1'b1;
        pick_q = qi;
        for (int i = NWG - 1; i >= 0; i--) begin
          if (p[qi][i]) pick_idx = i;
        end
      end
    end
  end

  assign wg = found ? WG_W'(pick_idx) : NO_WG;
  assign q  = found ? Q_W'(pick_q) : '0;

  // Signed int window bounds clip naturally at both ends; nothing wraps around.
  always_comb begin
    p_clr = p;
    if (found) begin
      for (int i = 0; i < NWG; i++) begin
        if ((i >= pick_idx - GHOST_W) && (i <= pick_idx + GHOST_W)) begin
          for (int k = 0; k < 4; k++) p_clr[k][i] = 1'b0;
        end
      end
    end
    any_left = (p_clr != '0);
  end
endmodule

// File: rtl/collider_seq.sv
// Frame-level track extraction scheduler: accepts one BX frame of four quality planes and
// emits up to MAX_TRK tracks, best first, through a registered pick / ghost-clear loop.
module collider_seq
  import collider_pkg::*;
#(
  parameter int NWG     = NWG_DEF,
  parameter int MAX_TRK = 4,
  parameter int GHOST_W = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NWG-1:0]  qp0,
  input  logic [NWG-1:0]  qp1,
  input  logic [NWG-1:0]  qp2,
  input  logic [NWG-1:0]  qp3,
  output logic            trk_valid,
  input  logic            trk_ready,
  output logic [WG_W-1:0] trk_wg,
  output logic [Q_W-1:0]  trk_q,
  output logic            trk_last,
  output logic            frame_done,
  output logic            overflow
);
  localparam logic [2:0] LAST_CNT = 3'(MAX_TRK - 1);

  state_t              state_q, state_d;
  logic [3:0][NWG-1:0] planes_q, planes_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [WG_W-1:0]     trk_wg_q, trk_wg_d;
  logic [Q_W-1:0]      trk_qual_q, trk_qual_d;
  logic                trk_last_q, trk_last_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;

  logic                pick_found;
  logic [WG_W-1:0]     pick_wg;
  logic [Q_W-1:0]      pick_q;
  logic [3:0][NWG-1:0] pick_planes;
  logic                pick_any_left;

  collider_pick #(
    .NWG     (NWG),
    .GHOST_W (GHOST_W)
  ) u_pick (
    .p        (planes_q),
    .found    (pick_found),
    .wg       (pick_wg),
    .q        (pick_q),
    .p_clr    (pick_planes),
    .any_left (pick_any_left)
  );

  always_comb begin
    state_d      = state_q;
    planes_d     = planes_q;
    cnt_d        = cnt_q;
    trk_wg_d     = trk_wg_q;
    trk_qual_d   = trk_qual_q;
    trk_last_d   = trk_last_q;
    frame_done_d = 1'b0;
    overflow_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          planes_d = {qp3, qp2, qp1, qp0};
          cnt_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (!pick_found) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          trk_wg_d   = pick_wg;
          trk_qual_d = pick_q;
          trk_last_d = (cnt_q == LAST_CNT) || !pick_any_left;
          planes_d   = pick_planes;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (trk_ready) begin
          cnt_d = cnt_q + 3'd1;
          if (trk_last_q) begin
            frame_done_d = 1'b1;
            overflow_d   = (planes_q != '0);
            planes_d     = '0;
            state_d      = IDLE;
          end else begin
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      planes_q     <= '0;
      cnt_q        <= '0;
      trk_wg_q     <= NO_WG;
      trk_qual_q   <= '0;
      trk_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      planes_q     <= planes_d;
      cnt_q        <= cnt_d;
      trk_wg_q     <= trk_wg_d;
      trk_qual_q   <= trk_qual_d;
      trk_last_q   <= trk_last_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign trk_valid  = (state_q == EMIT);
  assign trk_wg     = trk_wg_q;
  assign trk_q      = trk_qual_q;
  assign trk_last   = trk_last_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_collider_seq.sv
// Scoreboard bench for collider_seq: a frame-level reference model queues expected tracks
// and frame outcomes; a negedge monitor compares whatever the DUT presents.
module tb_collider_seq;
  import collider_pkg::*;

  localparam int NWG     = 48;
  localparam int MAX_TRK = 4;
  localparam int GHOST_W = 1;

  typedef struct {
    int wg;
    int q;
    bit last;
  } trk_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [NWG-1:0]  qp0, qp1, qp2, qp3;
  logic            trk_valid;
  logic            trk_ready;
  logic [WG_W-1:0] trk_wg;
  logic [Q_W-1:0]  trk_q;
  logic            trk_last;
  logic            frame_done;
  logic            overflow;

  int   checks = 0;
  int   errors = 0;
  trk_t exp_trk[$];
  bit   exp_ovf[$];
  int   done_due = 0;
  int   ready_mode = 0;
  bit   hold_ready = 0;
  int   ncyc = 0;
  int   last_hs = 0;
  int   trk_idx = 0;

  collider_seq #(
    .NWG     (NWG),
    .MAX_TRK (MAX_TRK),
    .GHOST_W (GHOST_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .qp0        (qp0),
    .qp1        (qp1),
    .qp2        (qp2),
    .qp3        (qp3),
    .trk_valid  (trk_valid),
    .trk_ready  (trk_ready),
    .trk_wg     (trk_wg),
    .trk_q      (trk_q),
    .trk_last   (trk_last),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event not expected at %0t", name, $time);
  endtask

  // Reference model: repeatedly take the best hit, wipe its window in every plane.
  task automatic model_frame(input logic [NWG-1:0] pl [4], output bit empty);
    bit   b [4][NWG];
    int   n, bq, bw;
    bit   any, stop;
    trk_t t;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < NWG; i++) b[k][i] = pl[k][i];
    n = 0;
    empty = 1;
    stop = 0;
    while (!stop) begin
      bq = -1;
      bw = 0;
      for (int q = 3; q >= 0; q--)
        for (int i = 0; i < NWG; i++)
          if (b[q][i] && bq < 0) begin
            bq = q;
            bw = i;
          end
      if (bq < 0) begin
        exp_ovf.push_back(1'b0);
        stop = 1;
      end else begin
        empty = 0;
        for (int i = bw - GHOST_W; i <= bw + GHOST_W; i++)
          if (i >= 0 && i < NWG)
            for (int k = 0; k < 4; k++) b[k][i] = 1'b0;
        n++;
        any = 0;
        for (int k = 0; k < 4; k++)
          for (int i = 0; i < NWG; i++) any |= b[k][i];
        t.wg = bw;
        t.q = bq;
        t.last = (n == MAX_TRK) || !any;
        exp_trk.push_back(t);
        if (t.last) begin
          exp_ovf.push_back(any);
          stop = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [NWG-1:0] a3, input logic [NWG-1:0] a2,
                               input logic [NWG-1:0] a1, input logic [NWG-1:0] a0);
    logic [NWG-1:0] pl [4];
    bit empty;
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) fail_now("in_ready_timeout");
    pl[0] = a0;
    pl[1] = a1;
    pl[2] = a2;
    pl[3] = a3;
    model_frame(pl, empty);
    qp0 = a0;
    qp1 = a1;
    qp2 = a2;
    qp3 = a3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    qp0 = $urandom();
    qp3 = $urandom();
    if (empty) done_due = 2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_trk.size() == 0 && exp_ovf.size() == 0 && done_due == 0 && in_ready) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frame_drain_timeout", n < 500, 1);
  endtask

  function automatic logic [NWG-1:0] bitv(input int idx);
    logic [NWG-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  initial begin
    trk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: trk_ready = 1'b1;
        2: trk_ready = 1'b0;
        default: trk_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: peek expected track each presented cycle, pop on handshake.
  initial begin
    trk_t t;
    bit   e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        trk_idx = 0;
      end else begin
        if (frame_done) begin
          check("done_timing", done_due, 1);
          check("done_in_ready", in_ready, 1);
          if (exp_ovf.size() == 0) fail_now("done_unexpected");
          else begin
            e = exp_ovf.pop_front();
            check("overflow", overflow, e);
          end
        end else begin
          if (done_due == 1) fail_now("done_missing");
          if (overflow) fail_now("overflow_without_done");
        end
        if (done_due > 0) done_due--;
        if (trk_valid) begin
          if (exp_trk.size() == 0) fail_now("trk_unexpected");
          else begin
            t = exp_trk[0];
            check("trk_wg", trk_wg, t.wg);
            check("trk_q", trk_q, t.q);
            check("trk_last", trk_last, t.last);
            check("in_ready_busy", in_ready, 0);
            if (trk_ready) begin
              void'(exp_trk.pop_front());
              if (hold_ready && trk_idx > 0) check("trk_spacing", ncyc - last_hs, 2);
              last_hs = ncyc;
              trk_idx++;
              if (t.last) begin
                done_due = 1;
                trk_idx = 0;
              end
            end
          end
        end
      end
    end
  end

  task automatic checkOutput();
    check("rst_in_ready", in_ready, 1);
    check("rst_trk_valid", trk_valid, 0);
    check("rst_trk_wg", trk_wg, 127);
    check("rst_trk_q", trk_q, 0);
    check("rst_trk_last", trk_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
  endtask

  initial begin
    logic [NWG-1:0] r [4];
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    qp0 = '0;
    qp1 = '0;
    qp2 = '0;
    qp3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(bitv(10), '0, '0, '0);
    wait_idle();

    ready_mode = 1;
    hold_ready = 1;
    @(posedge clk);
    #1;
    applyStimulus(bitv(5) | bitv(20), '0, bitv(30), '0);
    wait_idle();
    hold_ready = 0;
    ready_mode = 0;

    applyStimulus('0, bitv(0) | bitv(1) | bitv(47), '0, '0);
    wait_idle();

    applyStimulus('0, '0, '0, bitv(2) | bitv(6) | bitv(10) | bitv(14) | bitv(18) | bitv(22));
    wait_idle();

    applyStimulus('0, '0, '0, '0);
    wait_idle();

    // Stall then reset mid-EMIT: the frame must vanish at once.
    ready_mode = 2;
    @(posedge clk);
    #1;
    applyStimulus(bitv(3) | bitv(30), '0, bitv(12), '0);
    n = 0;
    while (!trk_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach_emit", trk_valid, 1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_trk_valid", trk_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_trk_wg", trk_wg, 127);
    exp_trk.delete();
    exp_ovf.delete();
    done_due = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;

    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 4; k++) begin
        r[k] = '0;
        n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, (f % 5 == 0) ? 10 : 3);
        for (int j = 0; j < n; j++) r[k][$urandom_range(0, NWG - 1)] = 1'b1;
      end
      applyStimulus(r[3], r[2], r[1], r[0]);
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
